cr_axi4s_mstr_mc: RTL and testbench
===================================

Name: cr_axi4s_mstr_mc

Overview:
Parametrised multi-channel successor to the single-FIFO AXI4-Stream output master. Drains N_CH first-word-fall-through FIFOs (TLV-parser output FIFOs, one per engine or stream) onto one AXI4-S master port. Arbitration is round-robin and, in packet mode, never splits a packet (tlast-atomic). A 2-entry output buffer gives full throughput with no combinational tready-to-rd path. The block sits between per-channel cr_tlvp outbound FIFOs and the module's axi4s_ob port.

Parameters:
N_CH, 4, number of input channels (1..16)
DATA_W, 64, tdata width in bits (multiple of 8)
USER_W, 8, tuser width
ARB_MODE, 0, 0 = packet-atomic round robin; 1 = beat-interleaved round robin
CH_W, max(1,$clog2(N_CH)), derived; width of channel index

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ch_empty  in  N_CH  per-channel FIFO empty; head data valid when 0
ch_tdata  in  N_CH*DATA_W  per-channel FIFO head data, channel i at [i*DATA_W +: DATA_W]
ch_tstrb  in  N_CH*DATA_W/8  per-channel head byte strobes
ch_tuser  in  N_CH*USER_W  per-channel head user field
ch_tlast  in  N_CH  per-channel head end-of-packet
ch_rd  out  N_CH  one-hot pop; at most one bit set per cycle
m_tvalid  out  1  AXI4-S valid
m_tready  in  1  AXI4-S ready
m_tdata  out  DATA_W  AXI4-S data
m_tstrb  out  DATA_W/8  AXI4-S strobes
m_tuser  out  USER_W  AXI4-S user
m_tlast  out  1  AXI4-S last
m_tid  out  CH_W  source channel of the current beat
pkt_done  out  1  one-cycle pulse when a tlast beat is accepted downstream
pkt_done_ch  out  CH_W  channel of that packet; valid with pkt_done
busy  out  1  high while any beat is buffered or a packet is open

Behaviour:
- Reset is synchronous and active-high; one clock. Under reset: ch_rd=0, m_tvalid=0, m_tdata/tstrb/tuser/tlast/tid=0, pkt_done=0, pkt_done_ch=0, busy=0, RR pointer=0, state=IDLE, buffer count=0.
- Reset mid-packet discards all buffered beats. Input FIFO contents are not touched.
- Output buffer: 2-entry FIFO holding {tdata,tstrb,tuser,tlast,tid}. m_tvalid = (count!=0), driven from a register. A beat transfers on m_tvalid&m_tready.
- Pop rule: ch_rd[sel] = !ch_empty[sel] & (count<2) & grant_valid. The pop decision uses count before this cycle's downstream transfer, so ch_rd has no combinational dependence on m_tready.
- A popped beat is written to the buffer in the same cycle, is visible on m_tvalid the next cycle, and gives 1-cycle latency from pop to output. Sustained throughput is 1 beat/cycle when m_tready is held at 1.
- Simultaneous push and downstream transfer: count is unchanged. Push with count==2 cannot occur.
- FSM (ARB_MODE=0):
  - IDLE: select the first non-empty channel at or after the RR pointer (wrapping at N_CH-1 to 0) and latch it as owner, go LOCK. If no channel is non-empty, stay in IDLE.
  - The grant is usable in the same cycle it is chosen, so a pop may occur in the IDLE cycle. When a pop occurs, latch owner and go LOCK unless the popped beat has tlast=1; in that case stay in IDLE and set RR pointer = owner+1 (mod N_CH).
  - LOCK: pop only from owner. An empty owner stalls the stream; no other channel is served. On popping a tlast beat, set RR pointer = owner+1 (mod N_CH) and go IDLE.
- ARB_MODE=1: no LOCK state. Every pop re-arbitrates, and the RR pointer advances to sel+1 after each pop. Downstream uses m_tid to demultiplex.
- With N_CH=1, the RR pointer stays 0 and the block reduces to a single-channel master.
- pkt_done is registered. It pulses the cycle after m_tvalid&m_tready&m_tlast, with pkt_done_ch = the tid of that beat.
- busy = (count!=0) | (state==LOCK).
- Data fields are passed through unmodified. tstrb is not checked.

Decomposition:
- Shared package gets CH_W derivation as a function and the mode constants ARB_PKT=0, ARB_BEAT=1.
- Sub-module cr_rr_arb: N_CH-wide round-robin priority picker, combinational. Inputs are a request vector and a pointer; outputs are one-hot grant plus encoded index. It is reused for every channel-select decision.
- The buffer is inline.

Test Plan:
1. Reset with ch0 holding a 3-beat packet (data 0x11,0x22,0x33, tlast on the third beat), m_tready=1: ch_rd[0] is high for 3 consecutive cycles. Three m_tvalid beats follow in 3 consecutive cycles with m_tid=0. pkt_done pulses once with pkt_done_ch=0.
2. ARB_MODE=0, ch1 and ch2 each hold a 2-beat packet, pointer=0: output order is ch1 b0, ch1 b1, ch2 b0, ch2 b1 with no interleave. The pointer ends at 3.
3. ARB_MODE=1, same stimulus as test 2: output m_tid sequence is 1,2,1,2.
4. m_tready low for 5 cycles during a 6-beat packet: count saturates at 2 and ch_rd stays 0 while full. No beat is lost or duplicated; all data arrives in order after tready rises.
5. Owner ch0 goes empty mid-packet while ch3 is non-empty: no pop from ch3 until ch0 supplies its tlast beat. ch3 is served next.
6. Assert rst with count=2 mid-packet: the next cycle m_tvalid=0, busy=0, pointer=0. A new packet on ch2 is then output cleanly with m_tid=2.

Source files
------------

// File: rtl/cr_axi4s_mstr_mc_pkg.sv
// Shared types and constants for the multi-channel AXI4-Stream output master.
// Channel-index width derivation and arbitration mode encodings live here.
package cr_axi4s_mstr_mc_pkg;

  localparam int ARB_PKT  = 0;
  localparam int ARB_BEAT = 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  function automatic int ch_w_f(input int n_ch);
    if (n_ch <= 1) begin
      return 1;
    end else begin
      return $clog2(n_ch);
    end
  endfunction

endpackage

// File: rtl/cr_axi4s_mstr_mc_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Produces a one-hot grant, the encoded index and a valid flag.
module cr_rr_arb
  import cr_axi4s_mstr_mc_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = ch_w_f(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] idx,
  output logic            vld
);

  logic [CH_W-1:0] cand_s;

  // scan channels in rotated order starting at ptr, keep the first hit
  always_comb begin
    gnt    = {N_CH{1'b0}};
    idx    = {CH_W{1'b0}};
    vld    = 1'b0;
    cand_s = {CH_W{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      cand_s = CH_W'((int'(ptr) + k) % N_CH);
      if (!vld && req[cand_s]) begin
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
        vld         = 1'b1;
      end else begin
        vld = vld;
      end
    end
  end

endmodule

// File: rtl/cr_axi4s_mstr_mc.sv
// Drains N_CH FWFT FIFOs onto one AXI4-Stream master via round-robin arbitration
// (packet-atomic or beat-interleaved) and a 2-entry registered output buffer.
module cr_axi4s_mstr_mc
  import cr_axi4s_mstr_mc_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 64,
  parameter int USER_W   = 8,
  parameter int ARB_MODE = 0,
  parameter int CH_W     = ch_w_f(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_empty,
  input  logic [N_CH*DATA_W-1:0]   ch_tdata,
  input  logic [N_CH*DATA_W/8-1:0] ch_tstrb,
  input  logic [N_CH*USER_W-1:0]   ch_tuser,
  input  logic [N_CH-1:0]          ch_tlast,
  output logic [N_CH-1:0]          ch_rd,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [DATA_W/8-1:0]      m_tstrb,
  output logic [USER_W-1:0]        m_tuser,
  output logic                     m_tlast,
  output logic [CH_W-1:0]          m_tid,
  output logic                     pkt_done,
  output logic [CH_W-1:0]          pkt_done_ch,
  output logic                     busy
);

  localparam int STRB_W = DATA_W / 8;

  state_e          state_r, state_nxt_s;
  logic [CH_W-1:0] rr_ptr_r, rr_ptr_nxt_s;
  logic [CH_W-1:0] owner_r, owner_nxt_s;
  logic [1:0]      count_r, count_nxt_s;
  logic            m_tvalid_r, pkt_done_r, busy_r;
  logic [CH_W-1:0] pkt_done_ch_r;

  logic [DATA_W-1:0] b_data_r [2];
  logic [STRB_W-1:0] b_strb_r [2];
  logic [USER_W-1:0] b_user_r [2];
  logic              b_last_r [2];
  logic [CH_W-1:0]   b_tid_r  [2];

  logic [N_CH-1:0]   arb_gnt_s;
  logic [CH_W-1:0]   arb_idx_s;
  logic              arb_vld_s;
  logic              lock_s, grant_valid_s, pop_s, xfer_s;
  logic [CH_W-1:0]   sel_s;
  logic [N_CH-1:0]   sel_oh_s;
  logic              in_empty_s, in_last_s;
  logic [DATA_W-1:0] in_data_s;
  logic [STRB_W-1:0] in_strb_s;
  logic [USER_W-1:0] in_user_s;

  function automatic logic [CH_W-1:0] ptr_inc(input logic [CH_W-1:0] p);
    if (int'(p) >= N_CH - 1) begin
      return {CH_W{1'b0}};
    end else begin
      return p + CH_W'(1'b1);
    end
  endfunction

  cr_rr_arb #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .req (~ch_empty),
    .ptr (rr_ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s),
    .vld (arb_vld_s)
  );

  assign lock_s = (ARB_MODE == ARB_PKT) && (state_r == ST_LOCK);
  assign xfer_s = m_tvalid_r & m_tready;

  // channel select: locked owner in packet mode, otherwise the arbiter's pick
  always_comb begin
    sel_s         = arb_idx_s;
    sel_oh_s      = arb_gnt_s;
    grant_valid_s = arb_vld_s;
    if (lock_s) begin
      sel_s         = owner_r;
      grant_valid_s = 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        sel_oh_s[i] = (owner_r == CH_W'(i));
      end
    end else begin
      grant_valid_s = arb_vld_s;
    end
  end

  // head-of-FIFO mux for the selected channel
  always_comb begin
    in_empty_s = 1'b1;
    in_last_s  = 1'b0;
    in_data_s  = {DATA_W{1'b0}};
    in_strb_s  = {STRB_W{1'b0}};
    in_user_s  = {USER_W{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if (sel_s == CH_W'(i)) begin
        in_empty_s = ch_empty[i];
        in_last_s  = ch_tlast[i];
        in_data_s  = ch_tdata[i*DATA_W +: DATA_W];
        in_strb_s  = ch_tstrb[i*STRB_W +: STRB_W];
        in_user_s  = ch_tuser[i*USER_W +: USER_W];
      end else begin
        in_empty_s = in_empty_s;
      end
    end
  end

  // pop uses the pre-transfer count so ch_rd never depends on m_tready
  assign pop_s = grant_valid_s & ~in_empty_s & (count_r < 2'd2);
  assign ch_rd = pop_s ? sel_oh_s : {N_CH{1'b0}};

  // arbitration state, owner and round-robin pointer update
  always_comb begin
    state_nxt_s  = state_r;
    owner_nxt_s  = owner_r;
    rr_ptr_nxt_s = rr_ptr_r;
    if (ARB_MODE == ARB_BEAT) begin
      state_nxt_s = ST_IDLE;
      if (pop_s) begin
        rr_ptr_nxt_s = ptr_inc(sel_s);
      end else begin
        rr_ptr_nxt_s = rr_ptr_r;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arb_vld_s) begin
            owner_nxt_s = arb_idx_s;
            if (pop_s && in_last_s) begin
              rr_ptr_nxt_s = ptr_inc(arb_idx_s);
            end else begin
              state_nxt_s = ST_LOCK;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOCK: begin
          if (pop_s && in_last_s) begin
            rr_ptr_nxt_s = ptr_inc(owner_r);
            state_nxt_s  = ST_IDLE;
          end else begin
            state_nxt_s = ST_LOCK;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // buffer occupancy: push and transfer in the same cycle cancel out
  always_comb begin
    case ({pop_s, xfer_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // registered state, output buffer (entry 0 is the presented beat) and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      rr_ptr_r      <= {CH_W{1'b0}};
      owner_r       <= {CH_W{1'b0}};
      count_r       <= 2'd0;
      m_tvalid_r    <= 1'b0;
      pkt_done_r    <= 1'b0;
      pkt_done_ch_r <= {CH_W{1'b0}};
      busy_r        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        b_data_r[i] <= {DATA_W{1'b0}};
        b_strb_r[i] <= {STRB_W{1'b0}};
        b_user_r[i] <= {USER_W{1'b0}};
        b_last_r[i] <= 1'b0;
        b_tid_r[i]  <= {CH_W{1'b0}};
      end
    end else begin
      state_r    <= state_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      owner_r    <= owner_nxt_s;
      count_r    <= count_nxt_s;
      m_tvalid_r <= (count_nxt_s != 2'd0);
      busy_r     <= (count_nxt_s != 2'd0) || (state_nxt_s == ST_LOCK);
      pkt_done_r <= xfer_s & b_last_r[0];
      if (xfer_s && b_last_r[0]) begin
        pkt_done_ch_r <= b_tid_r[0];
      end else begin
        pkt_done_ch_r <= pkt_done_ch_r;
      end
      case (count_r)
        2'd0: begin
          if (pop_s) begin
            b_data_r[0] <= in_data_s;
            b_strb_r[0] <= in_strb_s;
            b_user_r[0] <= in_user_s;
            b_last_r[0] <= in_last_s;
            b_tid_r[0]  <= sel_s;
          end else begin
            b_last_r[0] <= b_last_r[0];
          end
        end
        2'd1: begin
          if (pop_s && xfer_s) begin
            b_data_r[0] <= in_data_s;
            b_strb_r[0] <= in_strb_s;
            b_user_r[0] <= in_user_s;
            b_last_r[0] <= in_last_s;
            b_tid_r[0]  <= sel_s;
          end else if (pop_s) begin
            b_data_r[1] <= in_data_s;
            b_strb_r[1] <= in_strb_s;
            b_user_r[1] <= in_user_s;
            b_last_r[1] <= in_last_s;
            b_tid_r[1]  <= sel_s;
          end else begin
            b_last_r[0] <= b_last_r[0];
          end
        end
        2'd2: begin
          if (xfer_s) begin
            b_data_r[0] <= b_data_r[1];
            b_strb_r[0] <= b_strb_r[1];
            b_user_r[0] <= b_user_r[1];
            b_last_r[0] <= b_last_r[1];
            b_tid_r[0]  <= b_tid_r[1];
          end else begin
            b_last_r[0] <= b_last_r[0];
          end
        end
        default: b_last_r[0] <= b_last_r[0];
      endcase
    end
  end

  assign m_tvalid    = m_tvalid_r;
  assign m_tdata     = b_data_r[0];
  assign m_tstrb     = b_strb_r[0];
  assign m_tuser     = b_user_r[0];
  assign m_tlast     = b_last_r[0];
  assign m_tid       = b_tid_r[0];
  assign pkt_done    = pkt_done_r;
  assign pkt_done_ch = pkt_done_ch_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_cr_axi4s_mstr_mc.sv
// Bench for cr_axi4s_mstr_mc: packet-atomic (inst 0) and beat-interleaved (inst 1)
// instances fed from queue-modelled FIFOs and compared against a round-robin order model.
module tb_cr_axi4s_mstr_mc;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int UW = 8;
  localparam int CW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
    logic [CW-1:0] tid;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]    ch_empty [2];
  logic [N*DW-1:0] ch_tdata [2];
  logic [N*SW-1:0] ch_tstrb [2];
  logic [N*UW-1:0] ch_tuser [2];
  logic [N-1:0]    ch_tlast [2];
  logic [N-1:0]    ch_rd    [2];
  logic            m_tvalid [2];
  logic            m_tready [2];
  logic [DW-1:0]   m_tdata  [2];
  logic [SW-1:0]   m_tstrb  [2];
  logic [UW-1:0]   m_tuser  [2];
  logic            m_tlast  [2];
  logic [CW-1:0]   m_tid    [2];
  logic            pkt_done [2];
  logic [CW-1:0]   pkt_done_ch [2];
  logic            busy     [2];

  beat_t fq [2*N][$];
  beat_t hq [2*N][$];
  beat_t mq [2*N][$];
  beat_t xq [2][$];
  int            mptr [2];
  logic          exp_pd [2];
  logic [CW-1:0] exp_pd_ch [2];
  int            pd_cnt [2];
  logic [N-1:0]  rd_smp [2];
  logic          v_smp [2];
  logic          ready_fix [2];
  logic          rnd_ready;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cr_axi4s_mstr_mc #(.N_CH(N), .DATA_W(DW), .USER_W(UW), .ARB_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .ch_empty(ch_empty[0]), .ch_tdata(ch_tdata[0]),
    .ch_tstrb(ch_tstrb[0]), .ch_tuser(ch_tuser[0]), .ch_tlast(ch_tlast[0]),
    .ch_rd(ch_rd[0]), .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]),
    .m_tdata(m_tdata[0]), .m_tstrb(m_tstrb[0]), .m_tuser(m_tuser[0]),
    .m_tlast(m_tlast[0]), .m_tid(m_tid[0]), .pkt_done(pkt_done[0]),
    .pkt_done_ch(pkt_done_ch[0]), .busy(busy[0])
  );

  cr_axi4s_mstr_mc #(.N_CH(N), .DATA_W(DW), .USER_W(UW), .ARB_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .ch_empty(ch_empty[1]), .ch_tdata(ch_tdata[1]),
    .ch_tstrb(ch_tstrb[1]), .ch_tuser(ch_tuser[1]), .ch_tlast(ch_tlast[1]),
    .ch_rd(ch_rd[1]), .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]),
    .m_tdata(m_tdata[1]), .m_tstrb(m_tstrb[1]), .m_tuser(m_tuser[1]),
    .m_tlast(m_tlast[1]), .m_tid(m_tid[1]), .pkt_done(pkt_done[1]),
    .pkt_done_ch(pkt_done_ch[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    int idx;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < N; c++) begin
        idx = i * N + c;
        if (fq[idx].size() > 0) begin
          ch_empty[i][c]          = 1'b0;
          ch_tdata[i][c*DW +: DW] = fq[idx][0].data;
          ch_tstrb[i][c*SW +: SW] = fq[idx][0].strb;
          ch_tuser[i][c*UW +: UW] = fq[idx][0].user;
          ch_tlast[i][c]          = fq[idx][0].last;
        end else begin
          ch_empty[i][c]          = 1'b1;
          ch_tdata[i][c*DW +: DW] = {DW{1'b0}};
          ch_tstrb[i][c*SW +: SW] = {SW{1'b0}};
          ch_tuser[i][c*UW +: UW] = {UW{1'b0}};
          ch_tlast[i][c]          = 1'b0;
        end
      end
      m_tready[i] = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix[i];
    end
  endtask

  // One clock: drive at negedge, sample just before posedge, pop FIFOs after it.
  task automatic cycle();
    beat_t e;
    drive_inputs();
    #4;
    for (int i = 0; i < 2; i++) begin
      rd_smp[i] = ch_rd[i];
      v_smp[i]  = m_tvalid[i];
      check("rd_onehot_legal", {127'd0, (($countones(ch_rd[i]) <= 1) && ((ch_rd[i] & ch_empty[i]) == '0))}, 128'd1);
      check("pkt_done", pkt_done[i], exp_pd[i]);
      if (exp_pd[i]) check("pkt_done_ch", pkt_done_ch[i], exp_pd_ch[i]);
      if (pkt_done[i] === 1'b1) pd_cnt[i]++;
      exp_pd[i] = 1'b0;
      if ((m_tvalid[i] & m_tready[i]) === 1'b1) begin
        if (xq[i].size() == 0) begin
          check("unexpected_beat", m_tvalid[i], 1'b0);
        end else begin
          e = xq[i].pop_front();
          check("tdata", m_tdata[i], e.data);
          check("tstrb", m_tstrb[i], e.strb);
          check("tuser", m_tuser[i], e.user);
          check("tlast", m_tlast[i], e.last);
          check("tid",   m_tid[i],   e.tid);
          exp_pd[i]    = e.last;
          exp_pd_ch[i] = e.tid;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < N; c++)
        if (rd_smp[i][c] === 1'b1 && fq[i*N+c].size() > 0) void'(fq[i*N+c].pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int j = 0; j < 2*N; j++) begin
      fq[j].delete(); hq[j].delete(); mq[j].delete();
    end
    for (int i = 0; i < 2; i++) begin
      xq[i].delete(); mptr[i] = 0; exp_pd[i] = 1'b0; pd_cnt[i] = 0;
    end
    drive_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_beat(input int inst, input int ch, input logic [DW-1:0] d,
                           input logic last, input bit feed);
    beat_t b;
    b.data = d;
    b.strb = SW'($urandom);
    b.user = UW'($urandom);
    b.last = last;
    b.tid  = CW'(ch);
    mq[inst*N+ch].push_back(b);
    if (feed) fq[inst*N+ch].push_back(b);
    else      hq[inst*N+ch].push_back(b);
  endtask

  task automatic add_pkt(input int inst, input int ch, input int n);
    for (int k = 0; k < n; k++) push_beat(inst, ch, {$urandom, $urandom}, k == n - 1, 1'b1);
  endtask

  // Reference order: inst 0 emits whole packets, inst 1 single beats, each from
  // the first non-empty channel at/after the pointer, pointer then moves past it.
  task automatic model_run(input int inst);
    bit    done;
    int    f, c;
    beat_t b;
    done = 1'b0;
    while (!done) begin
      f = -1;
      for (int k = 0; k < N; k++) begin
        c = (mptr[inst] + k) % N;
        if (f < 0 && mq[inst*N+c].size() > 0) f = c;
      end
      if (f < 0) begin
        done = 1'b1;
      end else if (inst == 0) begin
        do begin
          b = mq[f].pop_front();
          xq[0].push_back(b);
        end while (!b.last && mq[f].size() > 0);
        mptr[0] = (f + 1) % N;
      end else begin
        b = mq[N+f].pop_front();
        xq[1].push_back(b);
        mptr[1] = (f + 1) % N;
      end
    end
  endtask

  function automatic bit all_empty();
    bit r;
    r = (xq[0].size() == 0) && (xq[1].size() == 0);
    for (int j = 0; j < 2*N; j++) if (fq[j].size() != 0 || hq[j].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !all_empty()) begin
      cycle();
      n++;
    end
    check("drain_done", all_empty(), 1'b1);
    cycle();
    cycle();
    for (int i = 0; i < 2; i++) begin
      check("idle_tvalid", m_tvalid[i], 1'b0);
      check("idle_busy", busy[i], 1'b0);
    end
    check("ptr0", u_dut0.rr_ptr_r, mptr[0]);
    check("ptr1", u_dut1.rr_ptr_r, mptr[1]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic any3;
    rst = 1'b1;
    rnd_ready = 1'b0;
    ready_fix[0] = 1'b1;
    ready_fix[1] = 1'b1;
    @(negedge clk);
    do_reset();

    // reset state
    for (int i = 0; i < 2; i++) begin
      check("rst_tvalid", m_tvalid[i], 1'b0);
      check("rst_busy", busy[i], 1'b0);
      check("rst_rd", ch_rd[i], 4'b0000);
      check("rst_pkt_done", pkt_done[i], 1'b0);
      check("rst_tdata", m_tdata[i], 64'd0);
      check("rst_tid", m_tid[i], 2'd0);
      check("rst_tlast", m_tlast[i], 1'b0);
    end
    check("rst_ptr0", u_dut0.rr_ptr_r, 2'd0);

    // 1: 3-beat packet on ch0, back-to-back pops and beats
    push_beat(0, 0, 64'h11, 1'b0, 1'b1);
    push_beat(0, 0, 64'h22, 1'b0, 1'b1);
    push_beat(0, 0, 64'h33, 1'b1, 1'b1);
    model_run(0);
    cycle(); check("t1_rd_c1", rd_smp[0], 4'b0001);
    cycle(); check("t1_rd_c2", rd_smp[0], 4'b0001); check("t1_v_c2", v_smp[0], 1'b1);
    cycle(); check("t1_rd_c3", rd_smp[0], 4'b0001); check("t1_v_c3", v_smp[0], 1'b1);
    cycle(); check("t1_v_c4", v_smp[0], 1'b1);
    drain(50);
    check("t1_pd_count", pd_cnt[0], 1);

    // 2/3: ch1 and ch2 two-beat packets, both modes
    do_reset();
    add_pkt(0, 1, 2); add_pkt(0, 2, 2);
    add_pkt(1, 1, 2); add_pkt(1, 2, 2);
    model_run(0); model_run(1);
    drain(100);
    check("t2_pd_count", pd_cnt[0], 2);

    // 4: backpressure during a 6-beat packet
    do_reset();
    add_pkt(0, 1, 6);
    model_run(0);
    cycle(); cycle();
    ready_fix[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (k >= 2) check("t4_no_rd_full", rd_smp[0], 4'b0000);
    end
    check("t4_count_sat", u_dut0.count_r, 2'd2);
    ready_fix[0] = 1'b1;
    drain(100);

    // 5: owner ch0 starves mid-packet, ch3 must wait
    do_reset();
    push_beat(0, 0, {$urandom, $urandom}, 1'b0, 1'b1);
    push_beat(0, 0, {$urandom, $urandom}, 1'b0, 1'b0);
    push_beat(0, 0, {$urandom, $urandom}, 1'b1, 1'b0);
    add_pkt(0, 3, 2);
    model_run(0);
    any3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      any3 = any3 | rd_smp[0][3];
    end
    check("t5_no_steal", any3, 1'b0);
    check("t5_busy_locked", busy[0], 1'b1);
    while (hq[0].size() > 0) fq[0].push_back(hq[0].pop_front());
    drain(100);

    // 6: reset with a full buffer mid-packet, then a clean ch2 packet
    do_reset();
    ready_fix[0] = 1'b0;
    add_pkt(0, 1, 6);
    model_run(0);
    cycle(); cycle(); cycle();
    check("t6_pre_count", u_dut0.count_r, 2'd2);
    do_reset();
    check("t6_tvalid", m_tvalid[0], 1'b0);
    check("t6_busy", busy[0], 1'b0);
    check("t6_ptr", u_dut0.rr_ptr_r, 2'd0);
    ready_fix[0] = 1'b1;
    add_pkt(0, 2, 3);
    model_run(0);
    drain(100);

    // randomized traffic with random backpressure on both instances
    rnd_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < N; c++)
          for (int p = 0; p < int'($urandom_range(0, 2)); p++)
            add_pkt(i, c, int'($urandom_range(1, 4)));
      model_run(0);
      model_run(1);
      drain(2000);
    end
    rnd_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
